fetch_stage: RTL and testbench
==============================

# fetch_stage

2-wide instruction fetch stage feeding `id_stage`.
- Holds the fetch PC and issues one aligned 64-bit instruction-memory request at a time.
- Buffers returned instructions in a small circular fetch queue and presents up to two `IF_ID_PACKET`s per cycle to decode.
- Redirects on decode-time predictions (`id_stage` `next_PC`) and on retire-time squashes; in-flight memory responses from the old path are discarded.

## Interface
Parameters:
- `FQ_DEPTH`, 4: fetch-queue entries; power of two, ≥4.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `squash` in 1: retire-time mispredict flush.
- `squash_PC` in 32: correct-path PC on `squash`.
- `id_redirect` in 1: decode predicted a taken branch or return.
- `id_redirect_PC` in 32: `next_PC` from `id_stage`.
- `id_ready` in 1: decode/dispatch accepts this cycle's valid outputs.
- `imem_req` out 1: request strobe; accepted in the same cycle.
- `imem_addr` out 32: request address, 8-byte aligned.
- `imem_resp_valid` in 1: response strobe, at least 1 cycle after the request.
- `imem_resp_data` in 64: `[31:0]` = word at `addr`, `[63:32]` = word at `addr+4`.
- `if_id_packet_out` out `IF_ID_PACKET [1:0]`: slot 0 is the oldest; fields `inst`, `PC`, `NPC` (= `PC+4`), `valid`.

## Operation
- **State machine** (`fetch_state_t`): REQ, WAIT, DISCARD.
  - REQ: `imem_req`=1 iff `FQ_DEPTH-count ≥ 2` and no redirect/squash this cycle. On request go to WAIT, else stay.
  - WAIT: on `imem_resp_valid`, enqueue the block, advance PC, go to REQ.
  - DISCARD: on `imem_resp_valid`, drop the data and go to REQ.
- **Addressing**: `imem_addr = {fetch_PC[31:3],3'b0}`.
  - On response with `fetch_PC[2]`=0: enqueue both words (PCs `A`, `A+4`).
  - On response with `fetch_PC[2]`=1: enqueue only the upper word (PC `A+4`).
  - In both cases `fetch_PC` becomes `A+8`.
- **Redirect**: `squash` has priority over `id_redirect`; both have priority over everything else. On either:
  - queue flushed (`count`=0);
  - `fetch_PC` = target;
  - state: WAIT without a response this cycle → DISCARD; WAIT with a response this cycle → REQ (response dropped); DISCARD stays DISCARD (PC still updated); REQ stays REQ.
- **Dequeue**:
  - `valid[0] = count≥1`, `valid[1] = count≥2`.
  - When `id_ready`=1, pop the number of valid slots.
  - Pops are ignored in a redirect cycle.
  - Enqueue and dequeue in the same cycle are both applied: `count += enq - deq`.
- **Queue overflow**: not reachable, because a request is issued only with ≥2 free entries and there is one outstanding request at most. An assertion checks `count ≤ FQ_DEPTH`.
- **Pointers**: head/tail wrap modulo `FQ_DEPTH`; `count` is `$clog2(FQ_DEPTH)+1` bits.

## Timing
- **Reset** (`reset`=0, async):
  - state REQ, `fetch_PC`=0, `count`=0, pointers 0;
  - all output `valid`=0, `PC`/`NPC`/`inst`=0;
  - `imem_addr`=0; `imem_req`=1 from the first cycle after release.
- **Outputs**: `imem_req`/`imem_addr` are combinational from state, `fetch_PC` and `count`. Packet outputs come combinationally from the queue head registers.
- **Best-case latency**: request at t, response at t+1, packets visible at t+2.
- **Redirect at t**:
  - from REQ: outputs invalid at t+1; request to the new target at t+1.
  - from WAIT: request at the cycle after the stale response arrives.
- **Reset mid-WAIT**: state returns to REQ. A late stale response arriving in REQ state is ignored.

## Structure
- **`sys_defs.svh`** holds `IF_ID_PACKET` (existing), `fetch_state_t`, and the `` `FQ_DEPTH `` default.
- **Sub-module `fetch_queue`**: 2-in/2-out circular buffer.
  - Inputs: enqueue count 0–2 with entries, pop count 0–2, flush.
  - Outputs: head two entries, `count`.
- **`fetch_stage`** owns the FSM, PC, redirect priority and request gating.

## Test plan
- **Reset release**, memory responds next cycle with `0x00000013_00100093` → cycle 2:
  - slot0 `PC`=0, `inst`=`0x00100093`;
  - slot1 `PC`=4, `inst`=`0x00000013`;
  - `imem_addr`=8.
- **Unaligned redirect**: `id_redirect` to `0x104` in REQ → next request at `0x100`; only one packet enqueued (`PC`=`0x104`); next request at `0x108`.
- **Back-pressure**: `id_ready`=0 with `FQ_DEPTH`=4 → after two responses `count`=4, `imem_req` stays 0. Raising `id_ready` pops 2 → request resumes next cycle.
- **Squash during WAIT**: `squash_PC`=`0x200`, response 3 cycles later → stale data never appears; first request after that response is `0x200`.
- **Priority**: `squash`(`0x300`) and `id_redirect`(`0x400`) in the same cycle → fetch from `0x300`, queue empty the next cycle.
- **Async reset in DISCARD** (`reset`=0 without a clock edge) → outputs invalid immediately. After release the first request is `0x0`; a stray response arriving in REQ is ignored.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types for the 2-wide fetch stage: decode packet, FSM encoding and
// fetch-queue entry layout.
package fetch_stage_pkg;

    localparam int FQ_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] PC;
        logic [31:0] NPC;
        logic        valid;
    } IF_ID_PACKET;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/fetch_stage_queue.sv
// Circular fetch queue: accepts 0-2 entries and pops 0-2 entries per cycle,
// exposing the two oldest entries combinationally.
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int  DEPTH = FQ_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic [1:0]       enq_cnt,
    input  fq_entry_t [1:0]  enq_entry,
    input  logic [1:0]       deq_cnt,
    output fq_entry_t [1:0]  head_entry,
    output logic [CNT_W-1:0] count
);

    fq_entry_t        mem_reg [DEPTH];
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_reg + PTR_W'(deq_cnt);
            tail_reg  <= tail_reg + PTR_W'(enq_cnt);
            count_reg <= count_reg + CNT_W'(enq_cnt) - CNT_W'(deq_cnt);
        end
    end

    // Entry storage carries no reset; slots beyond count are never presented.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            if (!flush && (enq_cnt > 2'(i))) begin
                mem_reg[tail_reg + PTR_W'(i)] <= enq_entry[i];
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_head
        assign head_entry[gi] = mem_reg[head_reg + PTR_W'(gi)];
    end

    assign count = count_reg;

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        count_reg <= CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_stage.sv
// 2-wide fetch: one outstanding aligned 64-bit imem request, redirect and
// squash handling with stale-response discard, and decode packet output.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int FQ_DEPTH = FQ_DEPTH_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              squash,
    input  logic [31:0]       squash_PC,
    input  logic              id_redirect,
    input  logic [31:0]       id_redirect_PC,
    input  logic              id_ready,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_resp_valid,
    input  logic [63:0]       imem_resp_data,
    output IF_ID_PACKET [1:0] if_id_packet_out
);

    localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

    fetch_state_t     state_reg;
    fetch_state_t     state_next;
    logic [31:0]      pc_reg;
    logic [31:0]      pc_next;
    logic [31:0]      blk_addr;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic             has_room;
    logic             fq_flush;
    logic [1:0]       enq_cnt;
    logic [1:0]       deq_cnt;
    fq_entry_t [1:0]  enq_entry;
    fq_entry_t [1:0]  head_entry;
    logic [CNT_W-1:0] fq_count;

    assign redirect    = squash | id_redirect;
    assign redirect_pc = squash ? squash_PC : id_redirect_PC;
    assign blk_addr    = {pc_reg[31:3], 3'b000};
    assign has_room    = (CNT_W'(FQ_DEPTH) - fq_count) >= CNT_W'(2);
    assign imem_req    = (state_reg == REQ) && has_room && !redirect;
    assign imem_addr   = blk_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= REQ;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        fq_flush   = 1'b0;
        enq_cnt    = 2'd0;
        deq_cnt    = 2'd0;
        enq_entry  = '0;
        if (redirect) begin
            fq_flush = 1'b1;
            pc_next  = redirect_pc;
            // A response landing in the redirect cycle closes the old request.
            if (state_reg != REQ) begin
                state_next = imem_resp_valid ? REQ : DISCARD;
            end
        end else begin
            if (id_ready) begin
                deq_cnt = (fq_count >= CNT_W'(2)) ? 2'd2 :
                          (fq_count != '0)        ? 2'd1 : 2'd0;
            end
            unique case (state_reg)
                REQ: begin
                    if (imem_req) state_next = WAIT;
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        state_next = REQ;
                        pc_next    = blk_addr + 32'd8;
                        if (pc_reg[2]) begin
                            enq_cnt      = 2'd1;
                            enq_entry[0] = '{inst: imem_resp_data[63:32], pc: pc_reg};
                        end else begin
                            enq_cnt      = 2'd2;
                            enq_entry[0] = '{inst: imem_resp_data[31:0],  pc: pc_reg};
                            enq_entry[1] = '{inst: imem_resp_data[63:32], pc: pc_reg + 32'd4};
                        end
                    end
                end
                DISCARD: begin
                    if (imem_resp_valid) state_next = REQ;
                end
                default: state_next = REQ;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH(FQ_DEPTH)
    ) u_fetch_queue (
        .clock     (clock),
        .reset     (reset),
        .flush     (fq_flush),
        .enq_cnt   (enq_cnt),
        .enq_entry (enq_entry),
        .deq_cnt   (deq_cnt),
        .head_entry(head_entry),
        .count     (fq_count)
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic slot_valid;
        assign slot_valid = fq_count > CNT_W'(gi);
        assign if_id_packet_out[gi] = slot_valid
            ? IF_ID_PACKET'{inst:  head_entry[gi].inst,
                            PC:    head_entry[gi].pc,
                            NPC:   head_entry[gi].pc + 32'd4,
                            valid: 1'b1}
            : '0;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: queue-level reference model checked every
// cycle plus literal expectations from the hand-worked scenarios.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              squash = 1'b0;
    logic [31:0]       squash_PC = '0;
    logic              id_redirect = 1'b0;
    logic [31:0]       id_redirect_PC = '0;
    logic              id_ready = 1'b0;
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_resp_valid = 1'b0;
    logic [63:0]       imem_resp_data = '0;
    IF_ID_PACKET [1:0] if_id_packet_out;

    fetch_stage #(.FQ_DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .squash          (squash),
        .squash_PC       (squash_PC),
        .id_redirect     (id_redirect),
        .id_redirect_PC  (id_redirect_PC),
        .id_ready        (id_ready),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_id_packet_out(if_id_packet_out)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0010_0093;
        if (a == 32'h4) return 32'h0000_0013;
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: fetched instructions as a plain queue of (pc, inst).
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ment_t;
    ment_t       m_q[$];
    logic [31:0] m_pc    = '0;
    bit          m_busy  = 1'b0;
    bit          m_stale = 1'b0;

    always @(negedge clock) begin
        bit          redir;
        bit          ereq;
        logic [31:0] tgt;
        logic [31:0] a;
        int          npop;
        redir = squash || id_redirect;
        tgt   = squash ? squash_PC : id_redirect_PC;
        if (!reset) begin
            chk("rst_addr", imem_addr, 32'h0);
            chk("rst_valid0", 32'(if_id_packet_out[0].valid), 32'h0);
            chk("rst_valid1", 32'(if_id_packet_out[1].valid), 32'h0);
            m_q.delete();
            m_pc    = '0;
            m_busy  = 1'b0;
            m_stale = 1'b0;
        end else begin
            ereq = !m_busy && ((DEPTH - m_q.size()) >= 2) && !redir;
            chk("model_req", 32'(imem_req), 32'(ereq));
            chk("model_addr", imem_addr, {m_pc[31:3], 3'b000});
            for (int s = 0; s < 2; s++) begin
                chk($sformatf("model_valid%0d", s), 32'(if_id_packet_out[s].valid),
                    32'(s < m_q.size()));
                if (s < m_q.size()) begin
                    chk($sformatf("model_pc%0d", s), if_id_packet_out[s].PC, m_q[s].pc);
                    chk($sformatf("model_npc%0d", s), if_id_packet_out[s].NPC, m_q[s].pc + 32'd4);
                    chk($sformatf("model_inst%0d", s), if_id_packet_out[s].inst, m_q[s].inst);
                end
            end
            if (redir) begin
                m_q.delete();
                m_pc = tgt;
                if (m_busy && imem_resp_valid) begin
                    m_busy  = 1'b0;
                    m_stale = 1'b0;
                end else if (m_busy) begin
                    m_stale = 1'b1;
                end
            end else begin
                npop = id_ready ? ((m_q.size() >= 2) ? 2 : m_q.size()) : 0;
                repeat (npop) void'(m_q.pop_front());
                if (imem_resp_valid && m_busy) begin
                    if (!m_stale) begin
                        a = {m_pc[31:3], 3'b000};
                        if (!m_pc[2]) m_q.push_back('{a, imem_resp_data[31:0]});
                        m_q.push_back('{a + 32'd4, imem_resp_data[63:32]});
                        m_pc = a + 32'd8;
                    end
                    m_busy  = 1'b0;
                    m_stale = 1'b0;
                end
                if (ereq) m_busy = 1'b1;
            end
        end
    end

    // Memory responder: answers each accepted request resp_lat cycles later.
    typedef struct { int due; logic [31:0] addr; } pend_t;
    pend_t pend_q[$];
    int    cyc      = 0;
    int    resp_lat = 1;

    task automatic tick();
        logic [31:0] a;
        @(negedge clock);
        if (reset && imem_req) pend_q.push_back('{cyc + resp_lat, imem_addr});
        @(posedge clock);
        #1;
        cyc++;
        squash          = 1'b0;
        id_redirect     = 1'b0;
        imem_resp_valid = 1'b0;
        if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            a               = pend_q[0].addr;
            imem_resp_valid = 1'b1;
            imem_resp_data  = {mem_word(a + 32'd4), mem_word(a)};
            $display("cycle %0d: resp addr=%h data=%h", cyc, a, imem_resp_data);
            void'(pend_q.pop_front());
        end
    endtask

    initial begin
        id_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_valid0", 32'(if_id_packet_out[0].valid), 32'h0);
        chk("reset_inst0", if_id_packet_out[0].inst, 32'h0);
        chk("reset_addr", imem_addr, 32'h0);

        // Reset release, first block at cycle 2.
        reset = 1'b1;
        cyc   = 0;
        tick();
        tick();
        chk("t1_pc0", if_id_packet_out[0].PC, 32'h0);
        chk("t1_inst0", if_id_packet_out[0].inst, 32'h0010_0093);
        chk("t1_npc0", if_id_packet_out[0].NPC, 32'h4);
        chk("t1_pc1", if_id_packet_out[1].PC, 32'h4);
        chk("t1_inst1", if_id_packet_out[1].inst, 32'h0000_0013);
        chk("t1_addr", imem_addr, 32'h8);

        // Unaligned redirect.
        id_redirect = 1'b1; id_redirect_PC = 32'h104;
        tick();
        chk("t2_flushed", 32'(if_id_packet_out[0].valid), 32'h0);
        chk("t2_addr", imem_addr, 32'h100);
        tick();
        tick();
        chk("t2_pc0", if_id_packet_out[0].PC, 32'h104);
        chk("t2_inst0", if_id_packet_out[0].inst, 32'hC0DE_0104);
        chk("t2_valid1", 32'(if_id_packet_out[1].valid), 32'h0);
        chk("t2_next_addr", imem_addr, 32'h108);

        // Back-pressure fills the queue.
        id_ready = 1'b0;
        id_redirect = 1'b1; id_redirect_PC = 32'h500;
        repeat (5) tick();
        chk("t3_full_req", 32'(imem_req), 32'h0);
        chk("t3_pc1", if_id_packet_out[1].PC, 32'h504);
        repeat (2) tick();
        chk("t3_hold_req", 32'(imem_req), 32'h0);
        chk("t3_hold_pc0", if_id_packet_out[0].PC, 32'h500);
        id_ready = 1'b1;
        tick();
        chk("t3_resume_req", 32'(imem_req), 32'h1);
        chk("t3_resume_addr", imem_addr, 32'h510);
        chk("t3_pc0", if_id_packet_out[0].PC, 32'h508);

        // Squash while waiting; response arrives 3 cycles after the request.
        resp_lat = 3;
        tick();
        squash = 1'b1; squash_PC = 32'h200;
        tick();
        resp_lat = 1;
        chk("t4_req_discard", 32'(imem_req), 32'h0);
        tick();
        tick();
        chk("t4_req", 32'(imem_req), 32'h1);
        chk("t4_addr", imem_addr, 32'h200);
        chk("t4_no_stale", 32'(if_id_packet_out[0].valid), 32'h0);
        tick();
        tick();
        chk("t4_pc0", if_id_packet_out[0].PC, 32'h200);

        // Squash beats decode redirect.
        squash = 1'b1; squash_PC = 32'h300;
        id_redirect = 1'b1; id_redirect_PC = 32'h400;
        tick();
        chk("t5_empty", 32'(if_id_packet_out[0].valid), 32'h0);
        chk("t5_addr", imem_addr, 32'h300);
        tick();
        tick();
        chk("t5_pc0", if_id_packet_out[0].PC, 32'h300);

        // Asynchronous reset while discarding.
        resp_lat = 4;
        tick();
        id_redirect = 1'b1; id_redirect_PC = 32'h600;
        tick();
        chk("t6_discard_addr", imem_addr, 32'h600);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_async_addr", imem_addr, 32'h0);
        chk("t6_async_valid", 32'(if_id_packet_out[0].valid), 32'h0);
        pend_q.delete();
        resp_lat = 1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        chk("t6_rel_req", 32'(imem_req), 32'h1);
        chk("t6_rel_addr", imem_addr, 32'h0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        tick();
        chk("t6_pc0", if_id_packet_out[0].PC, 32'h0);
        chk("t6_inst0", if_id_packet_out[0].inst, 32'h0010_0093);
        chk("t6_inst1", if_id_packet_out[1].inst, 32'h0000_0013);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
